octave_scan_ctrl: RTL and testbench

- Front-end sequencer for the octave filter bank. Accepts a raster pixel stream with a valid/ready handshake.
- Keeps the full-resolution X/Y scan counters and frame state. Decodes one enable per octave using the downsample pattern (every 2^o pixel in X and Y).
- For each octave, flags the cycles where the octave's DoG/Harris outputs are past pipeline warm-up, and supplies the downsampled window-centre coordinate for the keypoint stage.

---
 rtl/octave_scan_ctrl_pkg.sv | 30 +++
 rtl/octave_scan_ctrl_en_decode.sv | 66 ++++++
 rtl/octave_scan_ctrl.sv | 170 +++++++++++++++++
 tb/tb_octave_scan_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/octave_scan_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : octave_scan_ctrl_pkg
// Description : Shared types, constants and the octave enable decode helper
//               for the octave filter bank front-end sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package octave_scan_ctrl_pkg;

    // Width of every full-resolution and downsampled coordinate.
    localparam int COORD_W = 10;

    // Frame-level sequencer states.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    // True when (x, y) lies on the 2^oct downsample lattice of an octave.
    function automatic logic octaveHit(
        input logic [COORD_W-1:0] x,
        input logic [COORD_W-1:0] y,
        input int unsigned        oct
    );
        logic [COORD_W-1:0] mask;
        mask = COORD_W'((32'd1 << oct) - 32'd1);
        return ((x & mask) == '0) && ((y & mask) == '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/octave_scan_ctrl_en_decode.sv
`default_nettype none
// ============================================================================
// Module      : octave_en_decode
// Description : Per-octave enable, warm-up flag and downsampled centre
//               coordinate, registered one cycle after the accepted pixel.
// Revision    : 1.0 - initial release
// ============================================================================
module octave_en_decode
    import octave_scan_ctrl_pkg::*;
#(
    parameter int OCTAVE_N = 3,
    parameter int LAT_X    = 20,
    parameter int LAT_Y    = 18
) (
    input  logic                          clk,
    input  logic                          rst_p,
    input  logic                          i_accept,
    input  logic [COORD_W-1:0]            i_x,
    input  logic [COORD_W-1:0]            i_y,
    output logic [OCTAVE_N-1:0]           o_octEn,
    output logic [OCTAVE_N-1:0]           o_kpValid,
    output logic [COORD_W*OCTAVE_N-1:0]   o_kpX,
    output logic [COORD_W*OCTAVE_N-1:0]   o_kpY
);

    localparam logic [COORD_W-1:0] c_LAT_X = COORD_W'(LAT_X);
    localparam logic [COORD_W-1:0] c_LAT_Y = COORD_W'(LAT_Y);

    for (genvar o = 0; o < OCTAVE_N; o++) begin : g_octave
        logic [COORD_W-1:0] w_xs;
        logic [COORD_W-1:0] w_ys;
        logic               w_hit;
        logic               r_en;
        logic               r_kpValid;
        logic [COORD_W-1:0] r_kpX;
        logic [COORD_W-1:0] r_kpY;

        assign w_xs  = i_x >> o;
        assign w_ys  = i_y >> o;
        assign w_hit = i_accept && octaveHit(i_x, i_y, o);

        // Register the octave strobe; centre coordinates only move on a hit.
        always_ff @(posedge clk) begin
            if (rst_p) begin
                r_en      <= 1'b0;
                r_kpValid <= 1'b0;
                r_kpX     <= '0;
                r_kpY     <= '0;
            end else begin
                r_en      <= w_hit;
                r_kpValid <= w_hit && (w_xs >= c_LAT_X) && (w_ys >= c_LAT_Y);
                if (w_hit) begin
                    r_kpX <= w_xs - c_LAT_X;
                    r_kpY <= w_ys - c_LAT_Y;
                end
            end
        end

        assign o_octEn[o]                   = r_en;
        assign o_kpValid[o]                 = r_kpValid;
        assign o_kpX[o*COORD_W +: COORD_W]  = r_kpX;
        assign o_kpY[o*COORD_W +: COORD_W]  = r_kpY;
    end

endmodule
`default_nettype wire

// File: rtl/octave_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : octave_scan_ctrl
// Description : Front-end sequencer for the octave filter bank. Accepts a
//               raster pixel stream, tracks frame position and state, and
//               drives per-octave enables and keypoint centre coordinates.
// Revision    : 1.0 - initial release
// ============================================================================
module octave_scan_ctrl
    import octave_scan_ctrl_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int FRAME_W  = 640,
    parameter int FRAME_H  = 480,
    parameter int OCTAVE_N = 3,
    parameter int LAT_X    = 20,
    parameter int LAT_Y    = 18
) (
    input  logic                          clk,
    input  logic                          rst_p,
    input  logic                          in_valid,
    input  logic                          in_sof,
    input  logic [DATA_W-1:0]             in_data,
    output logic                          in_ready,
    input  logic                          hold,
    output logic [DATA_W-1:0]             oct_data,
    output logic [COORD_W-1:0]            oct_X,
    output logic [COORD_W-1:0]            oct_Y,
    output logic [OCTAVE_N-1:0]           oct_en,
    output logic [OCTAVE_N-1:0]           kp_valid,
    output logic [COORD_W*OCTAVE_N-1:0]   kp_x,
    output logic [COORD_W*OCTAVE_N-1:0]   kp_y,
    output logic                          frame_busy,
    output logic                          frame_done,
    output logic                          sync_err
);

    localparam logic [COORD_W-1:0] c_LAST_X = COORD_W'(FRAME_W - 1);
    localparam logic [COORD_W-1:0] c_LAST_Y = COORD_W'(FRAME_H - 1);
    localparam logic [COORD_W-1:0] c_ONE    = COORD_W'(1);

    logic [1:0]          r_state;
    logic [1:0]          w_stateNext;
    logic [COORD_W-1:0]  r_x;
    logic [COORD_W-1:0]  r_y;
    logic [COORD_W-1:0]  w_xNext;
    logic [COORD_W-1:0]  w_yNext;
    logic [COORD_W-1:0]  w_px;
    logic [COORD_W-1:0]  w_py;
    logic                w_ready;
    logic                w_accept;
    logic                w_take;
    logic                w_last;
    logic                w_syncErr;
    logic [DATA_W-1:0]   r_octData;
    logic [COORD_W-1:0]  r_octX;
    logic [COORD_W-1:0]  r_octY;
    logic                r_frameDone;
    logic                r_syncErr;

    // DONE is a one-cycle bubble so the frame boundary is never overrun.
    assign w_ready  = !rst_p && !hold && (r_state != ST_DONE);
    assign w_accept = in_valid && w_ready;

    // Next state, position of the accepted pixel and next counter values.
    always_comb begin
        w_stateNext = r_state;
        w_px        = r_x;
        w_py        = r_y;
        w_xNext     = r_x;
        w_yNext     = r_y;
        w_take      = 1'b0;
        w_last      = 1'b0;
        w_syncErr   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Pixels without a start-of-frame are consumed and discarded.
                if (w_accept && in_sof) begin
                    w_take      = 1'b1;
                    w_px        = '0;
                    w_py        = '0;
                    w_stateNext = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (w_accept) begin
                    w_take = 1'b1;
                    if (in_sof) begin
                        // A start-of-frame always restarts at the origin.
                        w_px      = '0;
                        w_py      = '0;
                        w_syncErr = (r_x != '0) || (r_y != '0);
                    end
                end
            end
            ST_DONE: begin
                w_stateNext = ST_IDLE;
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
        if (w_take) begin
            if (w_px == c_LAST_X) begin
                w_xNext = '0;
                w_yNext = w_py + c_ONE;
            end else begin
                w_xNext = w_px + c_ONE;
                w_yNext = w_py;
            end
            if ((w_px == c_LAST_X) && (w_py == c_LAST_Y)) begin
                w_last      = 1'b1;
                w_stateNext = ST_DONE;
                w_xNext     = '0;
                w_yNext     = '0;
            end
        end
    end

    // State, scan counters and the registered pixel/status outputs.
    always_ff @(posedge clk) begin
        if (rst_p) begin
            r_state     <= ST_IDLE;
            r_x         <= '0;
            r_y         <= '0;
            r_octData   <= '0;
            r_octX      <= '0;
            r_octY      <= '0;
            r_frameDone <= 1'b0;
            r_syncErr   <= 1'b0;
        end else begin
            r_state     <= w_stateNext;
            r_x         <= w_xNext;
            r_y         <= w_yNext;
            r_frameDone <= w_last;
            r_syncErr   <= w_syncErr;
            if (w_take) begin
                r_octData <= in_data;
                r_octX    <= w_px;
                r_octY    <= w_py;
            end
        end
    end

    octave_en_decode #(
        .OCTAVE_N (OCTAVE_N),
        .LAT_X    (LAT_X),
        .LAT_Y    (LAT_Y)
    ) u_enDecode (
        .clk       (clk),
        .rst_p     (rst_p),
        .i_accept  (w_take),
        .i_x       (w_px),
        .i_y       (w_py),
        .o_octEn   (oct_en),
        .o_kpValid (kp_valid),
        .o_kpX     (kp_x),
        .o_kpY     (kp_y)
    );

    assign in_ready   = w_ready;
    assign oct_data   = r_octData;
    assign oct_X      = r_octX;
    assign oct_Y      = r_octY;
    assign frame_busy = (r_state == ST_ACTIVE);
    assign frame_done = r_frameDone;
    assign sync_err   = r_syncErr;

endmodule
`default_nettype wire

// File: tb/tb_octave_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_octave_scan_ctrl
// Description : Directed self-checking bench for octave_scan_ctrl on a 4x4
//               frame with two octaves and a warm-up of one in X and Y.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_octave_scan_ctrl;

    localparam int DW = 8;
    localparam int FW = 4;
    localparam int FH = 4;
    localparam int ON = 2;
    localparam int LX = 1;
    localparam int LY = 1;

    logic            clk = 1'b0;
    logic            rst_p;
    logic            in_valid;
    logic            in_sof;
    logic [DW-1:0]   in_data;
    logic            in_ready;
    logic            hold;
    logic [DW-1:0]   oct_data;
    logic [9:0]      oct_X;
    logic [9:0]      oct_Y;
    logic [ON-1:0]   oct_en;
    logic [ON-1:0]   kp_valid;
    logic [10*ON-1:0] kp_x;
    logic [10*ON-1:0] kp_y;
    logic            frame_busy;
    logic            frame_done;
    logic            sync_err;

    octave_scan_ctrl #(
        .DATA_W (DW), .FRAME_W (FW), .FRAME_H (FH),
        .OCTAVE_N (ON), .LAT_X (LX), .LAT_Y (LY)
    ) dut (
        .clk (clk), .rst_p (rst_p), .in_valid (in_valid), .in_sof (in_sof),
        .in_data (in_data), .in_ready (in_ready), .hold (hold),
        .oct_data (oct_data), .oct_X (oct_X), .oct_Y (oct_Y),
        .oct_en (oct_en), .kp_valid (kp_valid), .kp_x (kp_x), .kp_y (kp_y),
        .frame_busy (frame_busy), .frame_done (frame_done), .sync_err (sync_err)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nFails  = 0;

    // Expected-behaviour state: 0 idle, 1 active, 2 done.
    int         tbState = 0;
    int         ex = 0;
    int         ey = 0;
    logic [9:0] lastX = '0;
    logic [9:0] lastY = '0;
    logic [7:0] lastD = '0;
    logic [9:0] kx0 = '0, ky0 = '0, kx1 = '0, ky1 = '0;

    // Observed-event tallies, compared against hand-derived counts.
    int cntEnAny, cntEn0, cntEn1, cntKv0, cntKv1, cntDone, cntSync;
    int kv1X, kv1Y, kv1Kx, kv1Ky;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clearTallies();
        cntEnAny = 0; cntEn0 = 0; cntEn1 = 0; cntKv0 = 0; cntKv1 = 0;
        cntDone = 0; cntSync = 0; kv1X = -1; kv1Y = -1; kv1Kx = -1; kv1Ky = -1;
    endtask

    // One clock of stimulus; all outputs compared one edge later.
    task automatic drive(input logic v, input logic s, input logic [7:0] d, input logic h);
        logic rdy, take, en1, kv0, kv1, done, serr;
        int   px, py;
        in_valid = v; in_sof = s; in_data = d; hold = h;
        #1;
        rdy = !h && (tbState != 2);
        checkVal("in_ready", in_ready, rdy);
        take = v && rdy && (tbState == 1 || s);
        serr = take && s && (tbState == 1) && (ex != 0 || ey != 0);
        px   = (take && s) ? 0 : ex;
        py   = (take && s) ? 0 : ey;
        en1  = take && (px % 2 == 0) && (py % 2 == 0);
        kv0  = take && (px >= LX) && (py >= LY);
        kv1  = en1 && (px / 2 >= LX) && (py / 2 >= LY);
        done = 1'b0;
        if (tbState == 2) begin
            tbState = 0;
        end else if (take) begin
            tbState = 1;
            lastX = 10'(px); lastY = 10'(py); lastD = d;
            kx0 = 10'(px - LX); ky0 = 10'(py - LY);
            if (en1) begin
                kx1 = 10'(px / 2 - LX); ky1 = 10'(py / 2 - LY);
            end
            if (px == FW - 1) begin ex = 0; ey = py + 1; end
            else begin ex = px + 1; ey = py; end
            if (px == FW - 1 && py == FH - 1) begin
                tbState = 2; ex = 0; ey = 0; done = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        checkVal("oct_data",   oct_data, lastD);
        checkVal("oct_X",      oct_X, lastX);
        checkVal("oct_Y",      oct_Y, lastY);
        checkVal("oct_en",     oct_en, {en1, take});
        checkVal("kp_valid",   kp_valid, {kv1, kv0});
        checkVal("kp_x",       kp_x, {kx1, kx0});
        checkVal("kp_y",       kp_y, {ky1, ky0});
        checkVal("frame_done", frame_done, done);
        checkVal("sync_err",   sync_err, serr);
        checkVal("frame_busy", frame_busy, tbState == 1);
        if (oct_en != '0) cntEnAny++;
        if (oct_en[0])    cntEn0++;
        if (oct_en[1])    cntEn1++;
        if (kp_valid[0])  cntKv0++;
        if (kp_valid[1]) begin
            cntKv1++;
            kv1X = oct_X; kv1Y = oct_Y; kv1Kx = kp_x[19:10]; kv1Ky = kp_y[19:10];
        end
        if (frame_done)   cntDone++;
        if (sync_err)     cntSync++;
    endtask

    // One cycle of reset while a pixel is offered; every output must clear.
    task automatic pulseReset();
        rst_p = 1'b1; in_valid = 1'b1; in_sof = 1'b0; in_data = 8'h77; hold = 1'b0;
        #1;
        checkVal("rst_in_ready", in_ready, 1'b0);
        @(posedge clk);
        #1;
        rst_p = 1'b0;
        checkVal("rst_oct_data", oct_data, 0);
        checkVal("rst_oct_XY",   {oct_X, oct_Y}, 0);
        checkVal("rst_oct_en",   oct_en, 0);
        checkVal("rst_kp_valid", kp_valid, 0);
        checkVal("rst_kp_x",     kp_x, 0);
        checkVal("rst_kp_y",     kp_y, 0);
        checkVal("rst_status",   {frame_busy, frame_done, sync_err}, 0);
        tbState = 0; ex = 0; ey = 0; lastX = '0; lastY = '0; lastD = '0;
        kx0 = '0; ky0 = '0; kx1 = '0; ky1 = '0;
    endtask

    initial begin
        rst_p = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_data = '0; hold = 1'b0;
        clearTallies();
        @(posedge clk); #1;
        @(posedge clk); #1;
        pulseReset();

        // Stray pixels before any start-of-frame are consumed silently.
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 8'hAA, 1'b0);
        checkVal("idle_no_en", cntEnAny, 0);

        // Full 4x4 frame with continuous valid.
        clearTallies();
        for (int i = 0; i < 16; i++) drive(1'b1, i == 0, 8'(i), 1'b0);
        checkVal("f1_accepts", cntEn0, 16);
        checkVal("f1_en1",     cntEn1, 4);
        checkVal("f1_kv0",     cntKv0, 9);
        checkVal("f1_kv1",     cntKv1, 1);
        checkVal("f1_kv1_pos", {kv1X[9:0], kv1Y[9:0]}, {10'd2, 10'd2});
        checkVal("f1_kv1_k",   {kv1Kx[9:0], kv1Ky[9:0]}, 0);
        checkVal("f1_done",    cntDone, 1);
        drive(1'b1, 1'b0, 8'h55, 1'b0);

        // Back-pressure for three cycles after column 2.
        clearTallies();
        for (int i = 0; i < 3; i++) drive(1'b1, i == 0, 8'(8'h40 + i), 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 8'hEE, 1'b1);
        checkVal("hold_no_en", cntEn0, 3);
        drive(1'b1, 1'b0, 8'h43, 1'b0);
        checkVal("hold_resume_X", oct_X, 3);
        for (int i = 4; i < 16; i++) drive(1'b1, 1'b0, 8'(8'h40 + i), 1'b0);
        checkVal("hold_accepts", cntEn0, 16);
        checkVal("hold_done",    cntDone, 1);
        drive(1'b0, 1'b0, 8'h00, 1'b0);

        // Start-of-frame at (1,2) restarts the frame with an error pulse.
        clearTallies();
        for (int i = 0; i < 9; i++) drive(1'b1, i == 0, 8'(i), 1'b0);
        drive(1'b1, 1'b1, 8'hC0, 1'b0);
        checkVal("sync_pulse", sync_err, 1);
        checkVal("sync_XY",    {oct_X, oct_Y}, 0);
        for (int i = 1; i < 16; i++) drive(1'b1, 1'b0, 8'(8'hC0 + i), 1'b0);
        checkVal("sync_count", cntSync, 1);
        checkVal("sync_done",  cntDone, 1);
        drive(1'b0, 1'b0, 8'h00, 1'b0);

        // Reset arriving at (3,1) abandons the frame.
        clearTallies();
        for (int i = 0; i < 7; i++) drive(1'b1, i == 0, 8'(i), 1'b0);
        pulseReset();
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        checkVal("rst_no_done", cntDone, 0);
        for (int i = 0; i < 16; i++) drive(1'b1, i == 0, 8'(8'h80 + i), 1'b0);
        checkVal("post_rst_accepts", cntEn0, 23);
        checkVal("post_rst_done",    cntDone, 1);
        drive(1'b0, 1'b0, 8'h00, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
`default_nettype wire
